// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the CPU fetch port and
// the load/store data port, one outstanding transaction at a time.
// Data requests win by default. When MEM_ARBITER_STARVE_GUARD_EN is defined,
// a 4-bit streak counter forces a fetch grant after STARVE_LIMIT consecutive
// contested data grants.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   if_req/if_addr    fetch request in;  if_gnt, if_rvalid, if_rdata out
//   d_req/d_we/d_be/  data request in;   d_gnt, d_rvalid, d_rdata out
//   d_addr/d_wdata
//   mem_req/we/be/    memory request out (held until mem_ready)
//   addr/wdata
//   mem_ready, mem_rvalid, mem_rdata   memory handshake in
//   busy              a transaction is in flight
module mem_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_W-1:0]     if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [DATA_W/8-1:0]   d_be,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_W/8-1:0]   mem_be,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_ready,
  input  logic                  mem_rvalid,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  busy
);

  localparam int unsigned BE_W = DATA_W / 8;

  // Reject an out-of-range starvation limit at elaboration.
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("mem_arbiter: STARVE_LIMIT must be in 1..15");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                own_d_q, own_d_d;   // 1: data port owns the transaction
  logic                we_q, we_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                mem_req_q, mem_req_d;
  logic                busy_q, busy_d;
  logic                force_if;
  logic                resp;

`ifdef MEM_ARBITER_STARVE_GUARD_EN
  logic [3:0]          streak_q, streak_d;

  // Fetch wins a contested IDLE cycle once data has won STARVE_LIMIT in a row.
  assign force_if = (streak_q == 4'(STARVE_LIMIT)) && if_req && d_req;
`else
  assign force_if = 1'b0;
`endif

  // Grant decode: combinational, only in IDLE, suppressed during reset.
  always_comb begin
    d_gnt  = 1'b0;
    if_gnt = 1'b0;
    if (!reset && state_q == S_IDLE) begin
      if (d_req && !force_if) begin
        d_gnt = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end
    end
  end

  // Response routing: same-cycle pass-through of the memory response to the owner.
  always_comb begin
    resp      = (state_q == S_WAIT) && mem_rvalid;
    if_rvalid = resp && !own_d_q;
    d_rvalid  = resp && own_d_q;
    if_rdata  = if_rvalid ? mem_rdata : '0;
    d_rdata   = (d_rvalid && !we_q) ? mem_rdata : '0;
  end

  // Next-state, request capture and starvation streak.
  always_comb begin
    state_d = state_q;
    own_d_d = own_d_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef MEM_ARBITER_STARVE_GUARD_EN
    streak_d = streak_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (d_gnt) begin
          state_d = S_ISSUE;
          own_d_d = 1'b1;
          we_d    = d_we;
          be_d    = d_be;
          addr_d  = d_addr;
          wdata_d = d_wdata;
`ifdef MEM_ARBITER_STARVE_GUARD_EN
          // Saturate so a streak can never wrap back below the limit.
          if (!if_req)                streak_d = 4'd0;
          else if (streak_q != 4'hF)  streak_d = streak_q + 4'd1;
`endif
        end else if (if_gnt) begin
          state_d = S_ISSUE;
          own_d_d = 1'b0;
          we_d    = 1'b0;
          be_d    = '1;
          addr_d  = if_addr;
          wdata_d = '0;
`ifdef MEM_ARBITER_STARVE_GUARD_EN
          streak_d = 4'd0;
`endif
        end
      end
      S_ISSUE: begin
        // Any mem_rvalid here is not ours and is ignored.
        if (mem_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rvalid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    mem_req_d = (state_d == S_ISSUE);
    busy_d    = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      own_d_q   <= 1'b0;
      we_q      <= 1'b0;
      be_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      mem_req_q <= 1'b0;
      busy_q    <= 1'b0;
`ifdef MEM_ARBITER_STARVE_GUARD_EN
      streak_q  <= 4'd0;
`endif
    end else begin
      state_q   <= state_d;
      own_d_q   <= own_d_d;
      we_q      <= we_d;
      be_q      <= be_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      mem_req_q <= mem_req_d;
      busy_q    <= busy_d;
`ifdef MEM_ARBITER_STARVE_GUARD_EN
      streak_q  <= streak_d;
`endif
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = we_q;
  assign mem_be    = be_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;

endmodule
